// File: rtl/sos_pkg.sv
// Shared definitions for the speed-of-sound ranging blocks (probe transmitter,
// distance calculator): FSM state encoding and common timing constants.
package sos_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    BURST,
    GUARD
  } probe_state_t;

  localparam int SAMPLE_RATE_HZ    = 24000;
  localparam int DEFAULT_MAX_DELAY = 256;
  localparam int DEFAULT_GUARD_LEN = 256;

endpackage

// File: rtl/probe_envelope.sv
// Combinational tone-burst sample generator: maps the burst sample index k to
// a ramped, square-wave signed sample. Kept stand-alone for chirp variants.
module probe_envelope #(
  parameter int                 HALF_PERIOD = 2,
  parameter int                 BURST_LEN   = 16,
  parameter int                 RAMP_SHIFT  = 2,
  parameter logic signed [15:0] AMPLITUDE   = 16'sd12000,
  parameter int                 K_W         = 5
) (
  input  logic        [K_W-1:0] k_in,
  output logic signed [15:0]    sample_out
);

  localparam int RAMP_LEN = 1 << RAMP_SHIFT;
  localparam int PW       = 16 + RAMP_SHIFT + 1;

  logic        [31:0]   w_k;
  logic        [31:0]   w_env;
  logic                 w_negative;
  logic signed [PW-1:0] w_product;
  logic signed [15:0]   w_mag;

  // Sign from the square-wave phase, magnitude from the trapezoid envelope.
  always_comb begin
    // NOTE: every signal written here gets a value first so no latch is inferred.
    w_k        = 32'(k_in);
    w_negative = ((w_k / 32'(HALF_PERIOD)) & 32'd1) != 32'd0;
    w_env      = w_k + 32'd1;
    if ((32'(BURST_LEN) - w_k) < w_env) w_env = 32'(BURST_LEN) - w_k;
    if (32'(RAMP_LEN) < w_env)          w_env = 32'(RAMP_LEN);
    // env never exceeds RAMP_LEN, so the shifted product always fits 16 bits.
    w_product  = PW'(AMPLITUDE) * $signed(PW'(w_env));
    w_mag      = 16'(w_product >>> RAMP_SHIFT);
    sample_out = w_negative ? -w_mag : w_mag;
  end

endmodule

// File: rtl/sos_probe_transmitter.sv
// Speaker-side probe transmitter: on request, waits for the next sample strobe,
// plays an enveloped square-wave burst with a time-zero marker on its first
// sample, then holds a silent guard interval before accepting another request.
module sos_probe_transmitter
  import sos_pkg::*;
#(
  parameter int                 HALF_PERIOD = 2,
  parameter int                 BURST_LEN   = 16,
  parameter int                 RAMP_SHIFT  = 2,
  parameter logic signed [15:0] AMPLITUDE   = 16'sd12000,
  parameter int                 GUARD_LEN   = DEFAULT_GUARD_LEN
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               step_in,
  input  logic               impulse_in,
  output logic signed [15:0] amp_out,
  output logic               impulse_out,
  output logic               busy_out,
  output logic               done_out
);

  localparam int K_W = $clog2(BURST_LEN + 1);
  localparam int G_W = $clog2(GUARD_LEN + 1);

  probe_state_t       r_state,     w_state_nxt;
  logic [K_W-1:0]     r_k,         w_k_nxt;
  logic [G_W-1:0]     r_guard_cnt, w_guard_nxt;
  logic signed [15:0] r_amp,       w_amp_nxt;
  logic               r_impulse,   w_impulse_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_done,      w_done_nxt;
  logic signed [15:0] w_sample;

  probe_envelope #(
    .HALF_PERIOD (HALF_PERIOD),
    .BURST_LEN   (BURST_LEN),
    .RAMP_SHIFT  (RAMP_SHIFT),
    .AMPLITUDE   (AMPLITUDE),
    .K_W         (K_W)
  ) u_envelope (
    .k_in       (r_k),
    .sample_out (w_sample)
  );

  // State, counters and registered outputs; reset silences the speaker at once.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_guard_cnt <= '0;
      r_amp       <= '0;
      r_impulse   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_guard_cnt <= w_guard_nxt;
      r_amp       <= w_amp_nxt;
      r_impulse   <= w_impulse_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and output decode; strobes only matter after a request is armed.
  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_guard_nxt   = r_guard_cnt;
    w_amp_nxt     = r_amp;
    w_impulse_nxt = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A strobe in the accepting cycle is deliberately not used.
        if (impulse_in) begin
          w_state_nxt = ARMED;
          w_busy_nxt  = 1'b1;
        end
      end
      ARMED: begin
        if (step_in) begin
          w_amp_nxt     = w_sample;
          w_impulse_nxt = 1'b1;
          w_k_nxt       = K_W'(1);
          w_state_nxt   = BURST;
        end
      end
      BURST: begin
        if (step_in) begin
          w_amp_nxt = w_sample;
          if (r_k == K_W'(BURST_LEN - 1)) begin
            w_k_nxt     = '0;
            w_guard_nxt = '0;
            w_state_nxt = GUARD;
          end else begin
            w_k_nxt = r_k + K_W'(1);
          end
        end
      end
      GUARD: begin
        if (step_in) begin
          w_amp_nxt = '0;
          if (r_guard_cnt == G_W'(GUARD_LEN - 1)) begin
            w_guard_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_guard_nxt = r_guard_cnt + G_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign amp_out     = r_amp;
  assign impulse_out = r_impulse;
  assign busy_out    = r_busy;
  assign done_out    = r_done;

endmodule
